// File: rtl/punc_mem_arbiter_if.sv
// punc_mem_arbiter_if
//   Bundles the CPU port, the debug port, the memory side and the busy flag
//   of the memory arbiter. Clock and reset remain plain module ports.
//
//   slave  : view taken by the arbiter (requests in, grants/read data out,
//            memory strobes out, memory read data in).
//   master : view taken by the environment driving the requesters and
//            modelling the memory.
interface punc_mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    // CPU port (fixed priority)
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // Debug port (starvation-protected)
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    // Memory side; mem_rdata is valid the cycle after a read strobe
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter
//   Two-port arbiter in front of a single-ported synchronous memory.
//   The CPU port has fixed priority; the debug port is guaranteed an access
//   after losing MAX_WAIT consecutive arbitrations while requesting.
//   Each access is IDLE/RESP -> ACCESS -> RESP, so the peak rate is one
//   access every two cycles.
//
// Ports
//   clk  : clock, rising edge.
//   rst  : asynchronous active-low reset.
//   bus  : punc_mem_arbiter_if.slave (CPU port, debug port, memory side,
//          busy).
module punc_mem_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    punc_mem_arbiter_if.slave      bus
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic              cpu_win, dbg_win;

    // Captured winner request
    logic              cap_we;
    logic              cap_dbg;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    // Output registers
    logic              mem_en_q, mem_we_q;
    logic              cpu_gnt_q, dbg_gnt_q;
    logic              cpu_rvalid_q, dbg_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic              busy_q;

    // ------------------------------------------------------------------
    // Next-state and arbitration
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        cpu_win      = 1'b0;
        dbg_win      = 1'b0;

        case (state)
            IDLE, RESP: begin
                // The debug port overrides the CPU once it has been starved.
                cpu_win   = bus.cpu_req && !(bus.dbg_req && wait_cnt == WAIT_LIMIT);
                dbg_win   = bus.dbg_req && !cpu_win;
                state_nxt = (bus.cpu_req || bus.dbg_req) ? ACCESS : IDLE;

                if (!bus.dbg_req || dbg_win) begin
                    wait_cnt_nxt = 4'd0;
                end else if (wait_cnt < WAIT_LIMIT) begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            ACCESS:  state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Capture and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_we       <= 1'b0;
            cap_dbg      <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            // Grant and strobe are high exactly in the cycle after a win,
            // which is the ACCESS cycle.
            mem_en_q  <= cpu_win || dbg_win;
            cpu_gnt_q <= cpu_win;
            dbg_gnt_q <= dbg_win;
            busy_q    <= (state_nxt != IDLE);

            if (cpu_win) begin
                cap_we    <= bus.cpu_we;
                cap_dbg   <= 1'b0;
                cap_addr  <= bus.cpu_addr;
                cap_wdata <= bus.cpu_wdata;
                mem_we_q  <= bus.cpu_we;
            end else if (dbg_win) begin
                cap_we    <= bus.dbg_we;
                cap_dbg   <= 1'b1;
                cap_addr  <= bus.dbg_addr;
                cap_wdata <= bus.dbg_wdata;
                mem_we_q  <= bus.dbg_we;
            end else begin
                mem_we_q  <= 1'b0;
            end

            // Leaving ACCESS for RESP: flag a read completion to its owner.
            cpu_rvalid_q <= (state == ACCESS) && !cap_we && !cap_dbg;
            dbg_rvalid_q <= (state == ACCESS) && !cap_we &&  cap_dbg;

            // Keep the returned word after the RESP cycle ends.
            if (cpu_rvalid_q) cpu_rdata_q <= bus.mem_rdata;
            if (dbg_rvalid_q) dbg_rdata_q <= bus.mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = cap_addr;
    assign bus.mem_wdata  = cap_wdata;
    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.dbg_gnt    = dbg_gnt_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.busy       = busy_q;

    // The memory word only exists during RESP, so the RESP cycle forwards it
    // straight from mem_rdata; the select is a register, and the held copy
    // takes over from the next cycle on.
    assign bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_rdata : cpu_rdata_q;
    assign bus.dbg_rdata  = dbg_rvalid_q ? bus.mem_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// tb_punc_mem_arbiter
//   Directed scenarios plus a randomized run checked against a
//   transaction-level model of the arbiter.
module tb_punc_mem_arbiter;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int MAX_WAIT = 4;

    logic clk;
    logic rst;

    punc_mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    punc_mem_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after the strobe.
    logic [DATA_W-1:0] mem_arr [0:255];
    logic [DATA_W-1:0] mem_rdata_q;
    logic              pl_en = 1'b0;
    logic [7:0]        pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem_arr[pl_addr] <= pl_data;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            mem_rdata_q <= mem_arr[bus.mem_addr[7:0]];
        end
    end
    assign bus.mem_rdata = mem_rdata_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [DATA_W-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++; if ({bus.mem_en, bus.mem_we, bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.busy} !== 7'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000000", {bus.mem_en, bus.mem_we, bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.busy}); end
        checks++; if (bus.mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0000", bus.mem_wdata); end
        checks++; if (bus.cpu_rdata !== 16'h0) begin failures++; $display("FAIL reset_cpu_rdata got=%h exp=0000", bus.cpu_rdata); end
        checks++; if (bus.dbg_rdata !== 16'h0) begin failures++; $display("FAIL reset_dbg_rdata got=%h exp=0000", bus.dbg_rdata); end
        rst = 1'b1;
        tick();
        checks++; if ({bus.busy, bus.mem_en} !== 2'b00) begin failures++; $display("FAIL reset_idle_after_release got=%b exp=00", {bus.busy, bus.mem_en}); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_cpu_read();
        preload(8'h30, 16'h1234);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030;
        tick();
        checks++; if ({bus.cpu_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we} !== 4'b1010) begin failures++; $display("FAIL cpu_read_access got=%b exp=1010", {bus.cpu_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we}); end
        checks++; if (bus.mem_addr !== 16'h0030) begin failures++; $display("FAIL cpu_read_addr got=%h exp=0030", bus.mem_addr); end
        bus.cpu_req = 1'b0;
        tick();
        checks++; if ({bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_gnt, bus.mem_en} !== 4'b1000) begin failures++; $display("FAIL cpu_read_resp got=%b exp=1000", {bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_gnt, bus.mem_en}); end
        checks++; if (bus.cpu_rdata !== 16'h1234) begin failures++; $display("FAIL cpu_read_data got=%h exp=1234", bus.cpu_rdata); end
        tick();
        checks++; if ({bus.cpu_rvalid, bus.busy} !== 2'b00) begin failures++; $display("FAIL cpu_read_done got=%b exp=00", {bus.cpu_rvalid, bus.busy}); end
        checks++; if (bus.cpu_rdata !== 16'h1234) begin failures++; $display("FAIL cpu_read_hold got=%h exp=1234", bus.cpu_rdata); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_dbg_write();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 16'h00FF; bus.dbg_wdata = 16'hBEEF;
        tick();
        checks++; if ({bus.dbg_gnt, bus.cpu_gnt, bus.mem_en, bus.mem_we} !== 4'b1011) begin failures++; $display("FAIL dbg_write_access got=%b exp=1011", {bus.dbg_gnt, bus.cpu_gnt, bus.mem_en, bus.mem_we}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== {16'h00FF, 16'hBEEF}) begin failures++; $display("FAIL dbg_write_bus got=%h exp=00ffbeef", {bus.mem_addr, bus.mem_wdata}); end
        bus.dbg_req = 1'b0;
        tick();
        checks++; if ({bus.dbg_rvalid, bus.cpu_rvalid, bus.mem_en} !== 3'b000) begin failures++; $display("FAIL dbg_write_no_rvalid got=%b exp=000", {bus.dbg_rvalid, bus.cpu_rvalid, bus.mem_en}); end
        checks++; if (mem_arr[8'hFF] !== 16'hBEEF) begin failures++; $display("FAIL dbg_write_mem got=%h exp=beef", mem_arr[8'hFF]); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_simultaneous();
        preload(8'h01, 16'h1111);
        preload(8'h02, 16'h2222);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0001;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0002;
        tick();
        checks++; if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b10) begin failures++; $display("FAIL simul_first_gnt got=%b exp=10", {bus.cpu_gnt, bus.dbg_gnt}); end
        bus.cpu_req = 1'b0;
        tick();
        checks++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 16'h1111}) begin failures++; $display("FAIL simul_cpu_data got=%h exp=11111", {bus.cpu_rvalid, bus.cpu_rdata}); end
        tick();
        checks++; if ({bus.cpu_gnt, bus.dbg_gnt, bus.mem_addr} !== {2'b01, 16'h0002}) begin failures++; $display("FAIL simul_second_gnt got=%h exp=10002", {bus.cpu_gnt, bus.dbg_gnt, bus.mem_addr}); end
        bus.dbg_req = 1'b0;
        tick();
        checks++; if ({bus.dbg_rvalid, bus.cpu_rvalid, bus.dbg_rdata} !== {2'b10, 16'h2222}) begin failures++; $display("FAIL simul_dbg_data got=%h exp=22222", {bus.dbg_rvalid, bus.cpu_rvalid, bus.dbg_rdata}); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_starvation();
        int ng     = 0;
        int last_g = -1;
        int peak   = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0020;
        for (int cyc = 0; cyc < 60 && ng < 10; cyc++) begin
            tick();
            if (int'(dut.wait_cnt) > peak) peak = int'(dut.wait_cnt);
            if (bus.cpu_gnt && bus.dbg_gnt) begin
                checks++; failures++; $display("FAIL starve_two_gnts cycle=%0d got=11 exp=one-hot", cyc);
            end else if (bus.cpu_gnt || bus.dbg_gnt) begin
                checks++; if (bus.dbg_gnt !== ((ng % (MAX_WAIT + 1)) == MAX_WAIT)) begin failures++; $display("FAIL starve_order grant=%0d got_dbg=%0b exp_dbg=%0b", ng, bus.dbg_gnt, (ng % (MAX_WAIT + 1)) == MAX_WAIT); end
                if (last_g >= 0) begin
                    checks++; if (cyc - last_g != 2) begin failures++; $display("FAIL starve_spacing grant=%0d got=%0d exp=2", ng, cyc - last_g); end
                end
                last_g = cyc;
                ng++;
            end
        end
        checks++; if (ng != 10) begin failures++; $display("FAIL starve_grant_count got=%0d exp=10", ng); end
        checks++; if (peak != MAX_WAIT) begin failures++; $display("FAIL starve_wait_peak got=%0d exp=%0d", peak, MAX_WAIT); end
        idle_inputs();
        tick();
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        preload(8'h01, 16'hA001);
        preload(8'h02, 16'hA002);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0001;
        tick();
        checks++; if ({bus.cpu_gnt, bus.busy, bus.mem_addr} !== {2'b11, 16'h0001}) begin failures++; $display("FAIL b2b_gnt1 got=%h exp=30001", {bus.cpu_gnt, bus.busy, bus.mem_addr}); end
        bus.cpu_addr = 16'h0002;
        tick();
        checks++; if ({bus.cpu_rvalid, bus.cpu_gnt, bus.busy, bus.cpu_rdata} !== {3'b101, 16'hA001}) begin failures++; $display("FAIL b2b_rv1 got=%h exp=5a001", {bus.cpu_rvalid, bus.cpu_gnt, bus.busy, bus.cpu_rdata}); end
        tick();
        checks++; if ({bus.cpu_gnt, bus.cpu_rvalid, bus.busy, bus.mem_addr} !== {3'b101, 16'h0002}) begin failures++; $display("FAIL b2b_gnt2 got=%h exp=50002", {bus.cpu_gnt, bus.cpu_rvalid, bus.busy, bus.mem_addr}); end
        bus.cpu_req = 1'b0;
        tick();
        checks++; if ({bus.cpu_rvalid, bus.busy, bus.cpu_rdata} !== {2'b11, 16'hA002}) begin failures++; $display("FAIL b2b_rv2 got=%h exp=3a002", {bus.cpu_rvalid, bus.busy, bus.cpu_rdata}); end
        tick();
        checks++; if ({bus.cpu_rvalid, bus.busy, bus.cpu_rdata} !== {2'b00, 16'hA002}) begin failures++; $display("FAIL b2b_end got=%h exp=0a002", {bus.cpu_rvalid, bus.busy, bus.cpu_rdata}); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030;
        tick();
        checks++; if (bus.cpu_gnt !== 1'b1) begin failures++; $display("FAIL rmid_gnt got=%b exp=1", bus.cpu_gnt); end
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        checks++; if ({bus.mem_en, bus.cpu_gnt, bus.busy, bus.cpu_rvalid, bus.mem_addr, bus.cpu_rdata} !== 36'h0) begin failures++; $display("FAIL rmid_async_clear got=%h exp=0", {bus.mem_en, bus.cpu_gnt, bus.busy, bus.cpu_rvalid, bus.mem_addr, bus.cpu_rdata}); end
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.cpu_rvalid, bus.mem_en, bus.cpu_gnt} !== 3'b000) begin failures++; $display("FAIL rmid_stale cycle=%0d got=%b exp=000", i, {bus.cpu_rvalid, bus.mem_en, bus.cpu_gnt}); end
        end
        bus.cpu_req = 1'b1;
        tick();
        checks++; if ({bus.cpu_gnt, bus.mem_en, bus.mem_addr} !== {2'b11, 16'h0030}) begin failures++; $display("FAIL rmid_fresh_gnt got=%h exp=30030", {bus.cpu_gnt, bus.mem_en, bus.mem_addr}); end
        bus.cpu_req = 1'b0;
        tick();
        checks++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 16'h1234}) begin failures++; $display("FAIL rmid_fresh_data got=%h exp=11234", {bus.cpu_rvalid, bus.cpu_rdata}); end
        tick();
    endtask

    // ------------------------------------------------------------------
    // Random traffic against a transaction model: an access started at an
    // edge blocks arbitration at the next edge; rvalid for a read appears
    // two cycles after its arbitration edge.
    task automatic test_random();
        logic [DATA_W-1:0] shadow [0:63];
        logic              l_start = 1'b0, l_we = 1'b0, l_dbg = 1'b0;
        logic [DATA_W-1:0] l_rd = '0;
        logic [DATA_W-1:0] e_rdc = '0, e_rdd = '0;
        logic              win_c, win_d, e_we, e_rvc, e_rvd, e_busy;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        int                wcnt = 0;

        rst = 1'b0;
        idle_inputs();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            shadow[i] = DATA_W'($urandom);
            preload(8'(8'h40 + i), shadow[i]);
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            e_rvc = l_start && !l_we && !l_dbg;
            e_rvd = l_start && !l_we &&  l_dbg;
            if (e_rvc) e_rdc = l_rd;
            if (e_rvd) e_rdd = l_rd;
            win_c = 1'b0; win_d = 1'b0;
            e_we = 1'b0; e_addr = '0; e_wd = '0;
            if (!l_start) begin
                if (bus.cpu_req && !(bus.dbg_req && wcnt == MAX_WAIT)) win_c = 1'b1;
                else if (bus.dbg_req)                                   win_d = 1'b1;
                if (!bus.dbg_req || win_d) wcnt = 0;
                else if (win_c)            wcnt = (wcnt + 1 > MAX_WAIT) ? MAX_WAIT : wcnt + 1;
            end
            if (win_c) begin e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata; end
            if (win_d) begin e_we = bus.dbg_we; e_addr = bus.dbg_addr; e_wd = bus.dbg_wdata; end
            if (win_c || win_d) begin
                if (e_we) shadow[e_addr[5:0]] = e_wd;
                else      l_rd = shadow[e_addr[5:0]];
            end
            e_busy  = win_c || win_d || l_start;
            l_start = win_c || win_d;
            l_we    = e_we;
            l_dbg   = win_d;
            #1;

            checks++; if ({bus.cpu_gnt, bus.dbg_gnt, bus.mem_en} !== {win_c, win_d, win_c || win_d}) begin failures++; $display("FAIL rnd_grant cycle=%0d got=%b exp=%b", cyc, {bus.cpu_gnt, bus.dbg_gnt, bus.mem_en}, {win_c, win_d, win_c || win_d}); end
            checks++; if (bus.busy !== e_busy) begin failures++; $display("FAIL rnd_busy cycle=%0d got=%b exp=%b", cyc, bus.busy, e_busy); end
            checks++; if ({bus.cpu_rvalid, bus.dbg_rvalid} !== {e_rvc, e_rvd}) begin failures++; $display("FAIL rnd_rvalid cycle=%0d got=%b exp=%b", cyc, {bus.cpu_rvalid, bus.dbg_rvalid}, {e_rvc, e_rvd}); end
            checks++; if (bus.cpu_rdata !== e_rdc) begin failures++; $display("FAIL rnd_cpu_rdata cycle=%0d got=%h exp=%h", cyc, bus.cpu_rdata, e_rdc); end
            checks++; if (bus.dbg_rdata !== e_rdd) begin failures++; $display("FAIL rnd_dbg_rdata cycle=%0d got=%h exp=%h", cyc, bus.dbg_rdata, e_rdd); end
            if (win_c || win_d) begin
                checks++; if ({bus.mem_we, bus.mem_addr} !== {e_we, e_addr}) begin failures++; $display("FAIL rnd_mem_cmd cycle=%0d got=%h exp=%h", cyc, {bus.mem_we, bus.mem_addr}, {e_we, e_addr}); end
                if (e_we) begin
                    checks++; if (bus.mem_wdata !== e_wd) begin failures++; $display("FAIL rnd_mem_wdata cycle=%0d got=%h exp=%h", cyc, bus.mem_wdata, e_wd); end
                end
            end

            // Requesters: drop or renew after a grant, occasionally withdraw.
            if (win_c ? ($urandom_range(1, 0) == 0) : (bus.cpu_req && $urandom_range(15, 0) == 0)) begin
                bus.cpu_req = 1'b0;
            end else if (win_c || (!bus.cpu_req && $urandom_range(2, 0) == 0)) begin
                bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom_range(1, 0));
                bus.cpu_addr = 16'h0040 | 16'($urandom_range(63, 0)); bus.cpu_wdata = DATA_W'($urandom);
            end
            if (win_d ? ($urandom_range(1, 0) == 0) : (bus.dbg_req && $urandom_range(15, 0) == 0)) begin
                bus.dbg_req = 1'b0;
            end else if (win_d || (!bus.dbg_req && $urandom_range(2, 0) == 0)) begin
                bus.dbg_req = 1'b1; bus.dbg_we = 1'($urandom_range(1, 0));
                bus.dbg_addr = 16'h0040 | 16'($urandom_range(63, 0)); bus.dbg_wdata = DATA_W'($urandom);
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_simultaneous();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/punc_mem_arbiter.md
PUNC_MEM_ARBITER -- requirements
Module: punc_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, range 1..15; debug-port starvation limit in lost arbitrations.
REQ-004 SHALL have one clock and an asynchronous active-low reset:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have the CPU port, which has fixed priority:
- cpu_req  input  1  access request.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  address.
- cpu_wdata  input  DATA_W  write data.
- cpu_gnt  output  1  one-cycle grant pulse.
- cpu_rvalid  output  1  one-cycle read-data-valid pulse.
- cpu_rdata  output  DATA_W  read data.
REQ-006 SHALL have the debug port, with signals dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid and dbg_rdata, identical in direction, width and meaning to REQ-005.
REQ-007 SHALL have the memory side:
- mem_en  output  1  access strobe.
- mem_we  output  1  write enable.
- mem_addr  output  ADDR_W  address.
- mem_wdata  output  DATA_W  write data.
- mem_rdata  input  DATA_W  read data, valid exactly one cycle after a cycle with mem_en=1 and mem_we=0.
REQ-008 SHALL have busy  output  1; high whenever the state is not IDLE.

Function
REQ-009 SHALL implement the FSM states IDLE, ACCESS and RESP, with all outputs driven from registers.
REQ-010 Arbitration SHALL be evaluated in IDLE and in RESP; if either request is high, the next state SHALL be ACCESS, otherwise IDLE.
REQ-011 The winner SHALL be the CPU if cpu_req=1, unless dbg_req=1 and wait_cnt==MAX_WAIT, in which case the debug port wins.
REQ-012 At the arbitration edge, the winner's we, addr, wdata and port id SHALL be captured into internal registers; the requester holds these signals stable until it sees its gnt.
REQ-013 In ACCESS (one cycle):
- mem_en=1.
- mem_we, mem_addr and mem_wdata equal the captured values.
- the winner's gnt=1; the other port's gnt=0.
REQ-014 ACCESS SHALL always be followed by RESP.
REQ-015 In RESP, for a read, the winner's rdata SHALL be loaded from mem_rdata and its rvalid SHALL be 1 for exactly that cycle.
REQ-016 In RESP, for a write, no rvalid SHALL be asserted.
REQ-017 Each port's rdata SHALL hold its last value until that port's next read completes.
REQ-018 Latency SHALL be:
- request sampled at edge N; gnt and mem_en high during cycle N+1; rvalid high during cycle N+2.
- back-to-back peak rate is one access per 2 cycles (RESP→ACCESS).
REQ-019 The 4-bit wait_cnt SHALL:
- increment at each arbitration edge where dbg_req=1 and the CPU wins;
- clear when the debug port is granted;
- clear at any arbitration evaluation where dbg_req=0;
- saturate at MAX_WAIT.
REQ-020 At most one gnt and at most one rvalid SHALL be high in any cycle; mem_en SHALL never be high outside ACCESS.
REQ-021 Requests arriving during ACCESS SHALL be ignored until RESP evaluation.
REQ-022 A port's req deasserted before its gnt SHALL be treated as withdrawn, and no access SHALL be issued for it.

Reset
REQ-023 While rst=0:
- state = IDLE.
- wait_cnt = 0.
- all captured registers = 0.
- mem_en, mem_we, mem_addr, mem_wdata = 0.
- both gnt and both rvalid = 0.
- both rdata = 0; busy = 0.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction immediately, with no later gnt, rvalid or mem_en for it.
REQ-025 The first arbitration SHALL occur at the first rising edge after rst deasserts.

Verification
REQ-026 Single CPU read:
- stimulus: cpu_req=1, cpu_we=0, cpu_addr=16'h0030; memory returns 16'h1234.
- response: cpu_gnt, mem_en and mem_addr=16'h0030 high the next cycle; cpu_rvalid=1 with cpu_rdata=16'h1234 the cycle after.
REQ-027 Debug write:
- stimulus: dbg_req=1, dbg_we=1, dbg_addr=16'h00FF, dbg_wdata=16'hBEEF.
- response: one ACCESS cycle with mem_we=1 and matching address/data; no dbg_rvalid.
REQ-028 Simultaneous requests:
- stimulus: both ports request.
- response: CPU granted first; the debug port is granted once the CPU drops req.
REQ-029 Starvation with MAX_WAIT=4:
- stimulus: cpu_req and dbg_req held high continuously.
- response: grant order CPU, CPU, CPU, CPU, DBG, then repeats; wait_cnt peaks at 4.
REQ-030 Reset mid-read:
- stimulus: rst pulled low during ACCESS.
- response: all outputs read 0 immediately; no rvalid after release; a fresh cpu_req after release completes normally.
REQ-031 Back-to-back CPU reads:
- stimulus: CPU reads 16'h0001 and 16'h0002 back to back.
- response: gnt pulses 2 cycles apart; rvalid pulses 2 cycles apart with the correct data; busy stays high throughout.
